mem_arbiter: RTL and testbench

- Single-port RAM arbiter between the instruction fetch path (icache side) and the data path (dcache side).
- Registered FSM grants the RAM to one requester at a time and drives ramREN/ramWEN/ramaddr/ramstore.
- Completes each transfer on ramstate == ACCESS and returns per-requester wait/ack.
- Sits between the cache pair and the RAM model; uses word_t and ramstate_t from cpu_types_pkg.

---
 rtl/mem_arbiter.sv | 99 +++++++++
 tb/tb_mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, icache vs dcache, data-first priority.
// Optional MEM_ARB_STARVE_GUARD_EN lets pending fetches win after STARVE_LIMIT data grants.
package cpu_types_pkg;
  parameter int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);
  typedef enum logic [1:0] {IDLE, IFETCH, DLOAD, DSTORE} state_t;
  state_t state, next;
  logic access, i_done, d_done, favor_i;
  assign access = ramstate == ACCESS;
  assign i_done = state == IFETCH && iREN && access;
  assign d_done = ((state == DLOAD && dREN) || (state == DSTORE && dWEN)) && access;
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      mem_err <= 1'b0;
    end else begin
      state   <= next;
      mem_err <= state != IDLE && ramstate == ERROR;
    end
  end
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK) begin
    if (!nRST || !iREN || i_done)
      cnt <= '0;
    else if (d_done && cnt < CW'(STARVE_LIMIT))
      cnt <= cnt + 1'b1;
  end
  assign favor_i = cnt >= CW'(STARVE_LIMIT);
`else
  assign favor_i = 1'b0;
`endif
  // A dropped request leaves the serving state without an ack; enables fall with the state.
  always_comb begin
    next     = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dREN | dWEN;
    iload    = i_done ? ramload : '0;
    dload    = (state == DLOAD && d_done) ? ramload : '0;
    case (state)
      IDLE:    next = (favor_i && iREN) ? IFETCH : dWEN ? DSTORE : dREN ? DLOAD : iREN ? IFETCH : IDLE;
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = iREN && !access;
        next    = (!iREN || access) ? IDLE : IFETCH;
      end
      DLOAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr;
        dwait   = dREN && !access;
        next    = (!dREN || access) ? IDLE : DLOAD;
      end
      default: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = dWEN && !access;
        next     = (!dWEN || access) ? IDLE : DSTORE;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors through a scoreboard queue, plus a starvation sequence.
module tb_mem_arbiter;
  typedef struct packed {
    logic rst_n; logic iren; logic [31:0] iaddr; logic dren; logic dwen;
    logic [31:0] daddr; logic [31:0] dstore; logic [31:0] ramload; logic [1:0] ramstate;
  } in_t;
  typedef struct packed {
    logic iwait; logic [31:0] iload; logic dwait; logic [31:0] dload; logic ren; logic wen;
    logic [31:0] addr; logic [31:0] store; logic err;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;
  localparam logic [1:0] FR = 2'd0, BS = 2'd1, AC = 2'd2, ER = 2'd3;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, n_rst, i_ren, d_ren, d_wen, i_wait, d_wait, ram_ren, ram_wen, mem_err;
  logic [31:0] i_addr, i_load, d_addr, d_store, d_load, ram_addr, ram_store, ram_load;
  logic [1:0] ram_state;
  int tests = 0, failed = 0, n = 0;
  vec_t tbl[32];
  out_t sb[$];
  always #5 clk = ~clk;
  mem_arbiter dut (
    .CLK(clk), .nRST(n_rst), .iREN(i_ren), .iaddr(i_addr), .iwait(i_wait), .iload(i_load),
    .dREN(d_ren), .dWEN(d_wen), .daddr(d_addr), .dstore(d_store), .dwait(d_wait), .dload(d_load),
    .ramREN(ram_ren), .ramWEN(ram_wen), .ramaddr(ram_addr), .ramstore(ram_store),
    .ramload(ram_load), .ramstate(ram_state), .mem_err(mem_err)
  );
  function automatic in_t mk_in(logic r, logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic [31:0] ds, logic [31:0] rl, logic [1:0] rs);
    return '{r, ir, ia, dr, dw, da, ds, rl, rs};
  endfunction
  function automatic out_t mk_out(logic iw, logic [31:0] il, logic dw, logic [31:0] dl, logic re,
                                  logic we, logic [31:0] ad, logic [31:0] st, logic er);
    return '{iw, il, dw, dl, re, we, ad, st, er};
  endfunction
  task automatic add(input in_t i, input out_t o);
    tbl[n] = '{i, o};
    n++;
  endtask
  task automatic step(input string name, input in_t i, input out_t o);
    out_t exp, act;
    {n_rst, i_ren, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_state} = i;
    sb.push_back(o);
    @(negedge clk);
    exp = sb.pop_front();
    act = '{i_wait, i_load, d_wait, d_load, ram_ren, ram_wen, ram_addr, ram_store, mem_err};
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    out_t z;
    z = '0;
    // reset held with both requests, then DLOAD wins
    add(mk_in(0, 1, 0, 1, 0, 0, 0, 0, FR), mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 1, 0, 1, 0, 0, 0, 0, FR), mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 1, 0, 1, 0, 32'h200, 0, 0, FR), mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 1, 0, 1, 0, 32'h200, 0, 32'h1234_5678, AC), mk_out(1, 0, 0, 32'h1234_5678, 1, 0, 32'h200, 0, 0));
    // fetch with BUSY, BUSY, ACCESS
    add(mk_in(1, 1, 32'h40, 0, 0, 0, 0, 0, FR), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 1, 32'h40, 0, 0, 0, 0, 32'h2001_0005, BS), mk_out(1, 0, 0, 0, 1, 0, 32'h40, 0, 0));
    add(mk_in(1, 1, 32'h40, 0, 0, 0, 0, 32'h2001_0005, BS), mk_out(1, 0, 0, 0, 1, 0, 32'h40, 0, 0));
    add(mk_in(1, 1, 32'h40, 0, 0, 0, 0, 32'h2001_0005, AC), mk_out(0, 32'h2001_0005, 0, 0, 1, 0, 32'h40, 0, 0));
    // contention: store first, fetch after the bubble
    add(mk_in(1, 1, 32'h44, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, FR), mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 1, 32'h44, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, BS), mk_out(1, 0, 1, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0));
    add(mk_in(1, 1, 32'h44, 0, 1, 32'h100, 32'hDEAD_BEEF, 0, AC), mk_out(1, 0, 0, 0, 0, 1, 32'h100, 32'hDEAD_BEEF, 0));
    add(mk_in(1, 1, 32'h44, 0, 0, 0, 0, 0, FR), mk_out(1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 1, 32'h44, 0, 0, 0, 0, 32'hCAFE_0001, AC), mk_out(0, 32'hCAFE_0001, 0, 0, 1, 0, 32'h44, 0, 0));
    // error then access
    add(mk_in(1, 0, 0, 1, 0, 32'h300, 0, 0, FR), mk_out(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 0, 0, 1, 0, 32'h300, 0, 32'hBAD, ER), mk_out(0, 0, 1, 0, 1, 0, 32'h300, 0, 0));
    add(mk_in(1, 0, 0, 1, 0, 32'h300, 0, 32'hAA, AC), mk_out(0, 0, 0, 32'hAA, 1, 0, 32'h300, 0, 1));
    // abort mid-transfer
    add(mk_in(1, 0, 0, 1, 0, 32'h304, 0, 0, FR), mk_out(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 0, 0, 1, 0, 32'h304, 0, 0, BS), mk_out(0, 0, 1, 0, 1, 0, 32'h304, 0, 0));
    add(mk_in(1, 0, 0, 0, 0, 32'h304, 0, 32'h99, BS), mk_out(0, 0, 0, 0, 1, 0, 32'h304, 0, 0));
    add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, BS), z);
    // read+write is a write; reset kills it with no ack
    add(mk_in(1, 0, 0, 1, 1, 32'h400, 32'h5555_AAAA, 0, FR), mk_out(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(0, 0, 0, 1, 1, 32'h400, 32'h5555_AAAA, 0, BS), mk_out(0, 0, 1, 0, 0, 1, 32'h400, 32'h5555_AAAA, 0));
    add(mk_in(1, 0, 0, 1, 1, 32'h400, 32'h5555_AAAA, 0, AC), mk_out(0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(mk_in(1, 0, 0, 1, 1, 32'h400, 32'h5555_AAAA, 32'h11, AC), mk_out(0, 0, 0, 0, 0, 1, 32'h400, 32'h5555_AAAA, 0));
    // ERROR while idle is not a served cycle
    add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, ER), z);
    add(mk_in(1, 0, 0, 0, 0, 0, 0, 0, FR), z);
    {i_ren, i_addr, d_ren, d_wen, d_addr, d_store, ram_load, ram_state} = '0;
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < n; k++) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);
    // iREN held against back-to-back loads; guard hands the 5th grant to the fetch
    for (int k = 0; k < 10; k++) begin
      bit f;
      f = GUARD && k / 2 == 4;
      step($sformatf("starve%0d", k), mk_in(1, 1, 32'h500, 1, 0, 32'h600, 0, 32'h77, AC),
           k % 2 == 0 ? mk_out(1, 0, 1, 0, 0, 0, 0, 0, 0) :
           f ? mk_out(0, 32'h77, 1, 0, 1, 0, 32'h500, 0, 0) :
               mk_out(1, 0, 0, 32'h77, 1, 0, 32'h600, 0, 0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
